dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single-port 16-bit data RAM between the Processor (port P) and a
//  host/loader port (port H) that preloads or dumps data memory. Sits between
//  Processor and the RAM in top_layer. Grants one access per cycle, routes each
//  read response back to its issuer, and prevents starvation of either side.
// PARAMETERS
//  AW        16  address width
//  DW        16  data width
//  RD_LAT    1   RAM read latency in cycles (legal 1..4)
//  HOLD_MAX  8   max consecutive P grants while H waits (legal 1..255)
// PORTS
//  clk        in   1    system clock, all state on rising edge
//  reset_n    in   1    asynchronous reset, active low
//  p_req      in   1    Processor requests an access
//  p_we       in   1    1 = write, 0 = read
//  p_addr     in   AW   Processor address
//  p_wdata    in   DW   Processor write data
//  p_gnt      out  1    access accepted this cycle (combinational)
//  p_rvalid   out  1    one-cycle pulse: p_rdata valid
//  p_rdata    out  DW   read data for P
//  h_req/h_we/h_addr/h_wdata/h_gnt/h_rvalid/h_rdata   same as P set, host side
//  mem_addr   out  AW   RAM address
//  mem_wdata  out  DW   RAM write data
//  mem_we     out  1    RAM write enable
//  mem_rdata  in   DW   RAM read data, valid RD_LAT cycles after the address
//  busy       out  1    any grant this cycle or any read in flight
// BEHAVIOUR
//  - Reset (async assert, sync deassert): gnt/rvalid/mem_we/busy=0, rdata=0,
//    mem_addr=0, mem_wdata=0, hold counter=0, state=IDLE, in-flight reads dropped.
//  - Handshake: requester holds req+we+addr+wdata stable until it sees gnt=1
//    at a rising edge; that edge is the acceptance. At most one gnt per cycle.
//  - Granted request drives mem_addr/mem_wdata/mem_we combinationally in the
//    same cycle; with no grant mem_we=0 and mem_addr/mem_wdata hold last value.
//  - Reads: RD_LAT-deep tag shift register records owner; exactly RD_LAT cycles
//    after acceptance the owner's rvalid pulses for 1 cycle with rdata=mem_rdata.
//    rdata holds its value until the next response to that port.
//  - Writes produce no response; a read accepted the cycle after a write to the
//    same address returns the written data (RAM order preserved).
//  - FSM (registered last owner): IDLE, OWN_P, OWN_H.
//    IDLE : p_req -> grant P, go OWN_P; else h_req -> grant H, go OWN_H.
//    OWN_P: both req -> grant P unless hold==HOLD_MAX, then grant H, go OWN_H.
//    OWN_H: both req -> grant P, go OWN_P (P has priority once H is served).
//    Single req -> grant it, move to its OWN state. No req -> IDLE.
//  - Hold counter: +1 per P grant while h_req=1, saturates at HOLD_MAX; clears
//    on any H grant or when h_req=0. H waits at most HOLD_MAX+1 cycles.
//  - Request withdrawn before gnt: no access issued, no lockup; re-arbitrate.
//  - Reset mid-read: pending rvalid pulses suppressed; none after release.
//  - busy = p_gnt | h_gnt | (any tag in flight).
// CONFIGURATION
//  ROUND_ROBIN_EN defined: when both request, grant alternates strictly
//    (opposite of last owner; IDLE starts with P); hold counter removed,
//    HOLD_MAX ignored.
//  Not defined: fixed P priority with HOLD_MAX starvation guard as above.
// TESTING
//  1 P read 0x0010 (RAM=0xBEEF), RD_LAT=1 -> p_gnt same cycle, p_rvalid 1 cycle
//    later, p_rdata=0xBEEF; h_rvalid stays 0.
//  2 H write 0x0004<=0x1234 then P read 0x0004 -> p_rdata=0x1234.
//  3 p_req and h_req held high 20 cycles, HOLD_MAX=8 -> grant pattern P x8, H,
//    P x8, H...; H never waits >9 cycles. Same with ROUND_ROBIN_EN -> P,H,P,H.
//  4 RD_LAT=3, back-to-back reads P@0x1,H@0x2,P@0x3 -> rvalid order P,H,P,
//    each exactly 3 cycles after its grant, data matched to address.
//  5 reset_n low 1 cycle between grant and response of a P read -> p_rvalid
//    never pulses, all outputs 0 during reset, normal grant next request.
//  6 h_req raised then dropped before gnt while P busy -> no H access on mem
//    bus, no h_rvalid, FSM returns to IDLE when P idle.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the Processor (P)
// and the host/loader port (H). One grant per cycle, read responses are
// routed back to their issuer through an RD_LAT-deep owner tag pipeline.
// Optional feature macro: ROUND_ROBIN_EN. When it is defined, the arbiter
// alternates strictly under contention. Otherwise P has fixed priority and a
// HOLD_MAX starvation guard protects H.
module dram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic [DW-1:0] p_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, OWN_P, OWN_H} state_t;

    state_t            state_reg;
    logic              grant_p;
    logic              grant_h;
    logic [RD_LAT-1:0] tag_p_reg;
    logic [RD_LAT-1:0] tag_h_reg;
    logic [AW-1:0]     addr_reg;
    logic [DW-1:0]     wdata_reg;
    logic [DW-1:0]     p_rdata_reg;
    logic [DW-1:0]     h_rdata_reg;

`ifndef ROUND_ROBIN_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
    logic [7:0] hold_reg;
`endif

    // Grant decision from the registered last owner; reset forces no grant.
    always_comb begin
        grant_p = 1'b0;
        grant_h = 1'b0;
        if (reset_n) begin
            if (p_req && h_req) begin
`ifdef ROUND_ROBIN_EN
                if (state_reg == OWN_P) grant_h = 1'b1;
                else                    grant_p = 1'b1;
`else
                if (state_reg == OWN_P && hold_reg == HOLD_LIM) grant_h = 1'b1;
                else                                            grant_p = 1'b1;
`endif
            end else if (p_req) begin
                grant_p = 1'b1;
            end else if (h_req) begin
                grant_h = 1'b1;
            end
        end
    end

    // Last-owner FSM: remembers who was served, drops to IDLE with no request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     state_reg <= IDLE;
        else if (grant_p) state_reg <= OWN_P;
        else if (grant_h) state_reg <= OWN_H;
        else              state_reg <= IDLE;
    end

`ifndef ROUND_ROBIN_EN
    // Counts P grants while H is kept waiting; saturates at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            hold_reg <= '0;
        else if (grant_h || !h_req)              hold_reg <= '0;
        else if (grant_p && hold_reg != HOLD_LIM) hold_reg <= hold_reg + 8'd1;
    end
`endif

    // Owner tag pipeline: a bit enters at read acceptance and leaves RD_LAT cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_p_reg <= '0;
            tag_h_reg <= '0;
        end else begin
            tag_p_reg[0] <= grant_p & ~p_we;
            tag_h_reg[0] <= grant_h & ~h_we;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_p_reg[i] <= tag_p_reg[i-1];
                tag_h_reg[i] <= tag_h_reg[i-1];
            end
        end
    end

    // Remember the last driven address/data so the bus holds when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (grant_p || grant_h) begin
            addr_reg  <= mem_addr;
            wdata_reg <= mem_wdata;
        end
    end

    // Keep each port's last response so rdata holds between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_rdata_reg <= '0;
            h_rdata_reg <= '0;
        end else begin
            if (p_rvalid) p_rdata_reg <= mem_rdata;
            if (h_rvalid) h_rdata_reg <= mem_rdata;
        end
    end

    assign p_gnt     = grant_p;
    assign h_gnt     = grant_h;
    assign mem_we    = (grant_p & p_we) | (grant_h & h_we);
    assign mem_addr  = grant_p ? p_addr  : (grant_h ? h_addr  : addr_reg);
    assign mem_wdata = grant_p ? p_wdata : (grant_h ? h_wdata : wdata_reg);
    assign p_rvalid  = tag_p_reg[RD_LAT-1];
    assign h_rvalid  = tag_h_reg[RD_LAT-1];
    assign p_rdata   = p_rvalid ? mem_rdata : p_rdata_reg;
    assign h_rdata   = h_rvalid ? mem_rdata : h_rdata_reg;
    assign busy      = grant_p | grant_h | (|tag_p_reg) | (|tag_h_reg);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model (shadow memory + response queue).
module tb_dram_arbiter;
    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int RD_LAT   = 3;
    localparam int HOLD_MAX = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p_req, p_we, h_req, h_we;
    logic [AW-1:0] p_addr, h_addr;
    logic [DW-1:0] p_wdata, h_wdata;
    logic          p_gnt, p_rvalid, h_gnt, h_rvalid;
    logic [DW-1:0] p_rdata, h_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, busy;

    always #5 clk = ~clk;

    dram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [15:0] pattern(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : {a[7:0] ^ 8'hA5, ~a[7:0]};
    endfunction

    // RAM with RD_LAT-cycle read latency
    logic [15:0] ram [0:255];
    logic [15:0] rd_pipe [0:RD_LAT-1];
    logic        preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= pattern(16'(i));
        end else if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        rd_pipe[0] <= ram[mem_addr[7:0]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model state
    typedef struct {int due; bit is_h; logic [15:0] data;} resp_t;
    resp_t       rq[$];
    logic [15:0] shadow [0:255];
    int          owner;      // 0 none, 1 P, 2 H
    int          hold;
    int          cyc;
    logic [15:0] last_addr, last_wdata, p_last, h_last;
    logic        got_pg, got_hg, got_prv, got_hrv;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model, advance the model.
    task automatic step(input logic rn, input logic pr, input logic pw, input logic [15:0] pa,
                        input logic [15:0] pd, input logic hr, input logic hw,
                        input logic [15:0] ha, input logic [15:0] hd);
        logic ep, eh, erp, erh, ewe, ebusy;
        logic [15:0] ea, ed;
        resp_t r;
        @(negedge clk);
        reset_n = rn; p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        #1;
        ep = 1'b0; eh = 1'b0;
        if (!rn) begin
            rq.delete(); owner = 0; hold = 0;
            last_addr = '0; last_wdata = '0; p_last = '0; h_last = '0;
        end else if (pr && hr) begin
`ifdef ROUND_ROBIN_EN
            eh = (owner == 1);
`else
            eh = (owner == 1) && (hold == HOLD_MAX);
`endif
            ep = !eh;
        end else begin
            ep = pr;
            eh = hr;
        end
        ebusy = ep | eh | (rq.size() > 0);
        erp = 1'b0; erh = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.is_h) begin erh = 1'b1; h_last = r.data; end
            else        begin erp = 1'b1; p_last = r.data; end
        end
        if (ep)      begin ea = pa; ed = pd; ewe = pw; end
        else if (eh) begin ea = ha; ed = hd; ewe = hw; end
        else         begin ea = last_addr; ed = last_wdata; ewe = 1'b0; end

        check("p_gnt",     32'(p_gnt),     32'(ep));
        check("h_gnt",     32'(h_gnt),     32'(eh));
        check("mem_we",    32'(mem_we),    32'(ewe));
        check("mem_addr",  32'(mem_addr),  32'(ea));
        check("mem_wdata", 32'(mem_wdata), 32'(ed));
        check("p_rvalid",  32'(p_rvalid),  32'(erp));
        check("h_rvalid",  32'(h_rvalid),  32'(erh));
        check("p_rdata",   32'(p_rdata),   32'(p_last));
        check("h_rdata",   32'(h_rdata),   32'(h_last));
        check("busy",      32'(busy),      32'(ebusy));

        if (ep || eh) begin
            last_addr = ea; last_wdata = ed;
            if (ewe) begin
                shadow[ea[7:0]] = ed;
            end else begin
                r.due = cyc + RD_LAT; r.is_h = eh; r.data = shadow[ea[7:0]];
                rq.push_back(r);
            end
            owner = ep ? 1 : 2;
        end else begin
            owner = 0;
        end
        if (rn) begin
            if (!hr || eh)                     hold = 0;
            else if (ep && hold < HOLD_MAX)    hold++;
        end
        cyc++;
        got_pg = p_gnt; got_hg = h_gnt; got_prv = p_rvalid; got_hrv = h_rvalid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic do_p(input logic we, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        do begin
            step(1'b1, 1'b1, we, a, d, 1'b0, 1'b0, 16'h0, 16'h0);
            n++;
        end while (!got_pg && n < 50);
        if (!got_pg) check("p_gnt_timeout", 32'd0, 32'd1);
        else $display("[TB] P %s @%04h data %04h granted cyc %0d", we ? "wr" : "rd", a, d, cyc - 1);
    endtask

    task automatic do_h(input logic we, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, we, a, d);
            n++;
        end while (!got_hg && n < 50);
        if (!got_hg) check("h_gnt_timeout", 32'd0, 32'd1);
        else $display("[TB] H %s @%04h data %04h granted cyc %0d", we ? "wr" : "rd", a, d, cyc - 1);
    endtask

    task automatic wait_prv(output logic [15:0] d, output int lat);
        lat = 0;
        do begin
            idle(1);
            lat++;
        end while (!got_prv && lat < 10);
        d = p_rdata;
        if (!got_prv) check("p_rvalid_timeout", 32'd0, 32'd1);
        else $display("[TB] P response %04h after %0d cycles", d, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int lat, hwait, max_w, np, p_first, cnt, ord_n;
        logic [2:0] ord;
        logic pp, pw_r, hp, hw_r, rn;
        logic [15:0] pa_r, pd_r, ha_r, hd_r;

        reset_n = 1'b0; p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = pattern(16'(i));
        cyc = 0; owner = 0; hold = 0;
        last_addr = '0; last_wdata = '0; p_last = '0; h_last = '0;

        // reset state, with a request pending that must not be granted
        step(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, 1'b1, 1'b1, 16'h0004, 16'h1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        preload = 1'b0;
        idle(2);

        // 1: P read of a preloaded word
        do_p(1'b0, 16'h0010, 16'h0);
        wait_prv(d, lat);
        check("t1_rdata", 32'(d), 32'hBEEF);
        check("t1_latency", 32'(lat), 32'(RD_LAT));
        idle(2);

        // 2: H write immediately followed by P read of the same address
        do_h(1'b1, 16'h0004, 16'h1234);
        do_p(1'b0, 16'h0004, 16'h0);
        wait_prv(d, lat);
        check("t2_rdata", 32'(d), 32'h1234);
        idle(3);

        // 3: both requesting continuously
        hwait = 0; max_w = 0; np = 0; p_first = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, 16'h0005, 16'(i), 1'b1, 1'b0, 16'h0006, 16'h0);
            if (got_hg) begin
                if (p_first < 0) p_first = np;
                if (hwait + 1 > max_w) max_w = hwait + 1;
                hwait = 0;
            end else begin
                hwait++;
                if (got_pg) np++;
            end
        end
`ifdef ROUND_ROBIN_EN
        check("t3_p_run", 32'(p_first), 32'd1);
`else
        check("t3_p_run", 32'(p_first), 32'(HOLD_MAX));
`endif
        check("t3_h_wait_bound", 32'(max_w <= HOLD_MAX + 1), 32'd1);
        idle(RD_LAT + 2);

        // 4: back-to-back reads P, H, P
        step(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        ord = 3'b000; ord_n = 0;
        for (int i = 0; i < RD_LAT + 3; i++) begin
            idle(1);
            if (got_prv || got_hrv) begin
                ord = {ord[1:0], got_hrv};
                ord_n++;
            end
        end
        check("t4_resp_count", 32'(ord_n), 32'd3);
        check("t4_resp_order", 32'(ord), 32'b010);
        idle(2);

        // 5: reset between grant and response of a P read
        do_p(1'b0, 16'h0007, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        cnt = 0;
        for (int i = 0; i < RD_LAT + 3; i++) begin
            idle(1);
            if (got_prv) cnt++;
        end
        check("t5_no_rvalid", 32'(cnt), 32'd0);
        step(1'b1, 1'b1, 1'b0, 16'h0008, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("t5_regrant", 32'(got_pg), 32'd1);
        idle(RD_LAT + 2);

        // 6: H request withdrawn while P keeps the RAM busy
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'(i), 16'h0, (i == 1 || i == 2), 1'b1, 16'h0009, 16'hDEAD);
            if (got_hg) cnt++;
        end
        for (int i = 0; i < RD_LAT + 2; i++) begin
            idle(1);
            if (got_hrv) cnt++;
        end
`ifndef ROUND_ROBIN_EN
        check("t6_no_h_activity", 32'(cnt), 32'd0);
`endif
        do_h(1'b0, 16'h0009, 16'h0);
        idle(RD_LAT + 2);

        // randomized traffic with withdrawals and occasional resets
        pp = 1'b0; hp = 1'b0; pw_r = 1'b0; hw_r = 1'b0;
        pa_r = '0; pd_r = '0; ha_r = '0; hd_r = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pp && $urandom_range(0, 99) < 45) begin
                pp = 1'b1; pw_r = 1'($urandom_range(0, 1));
                pa_r = 16'($urandom_range(0, 15)); pd_r = 16'($urandom);
            end else if (pp && $urandom_range(0, 99) < 4) begin
                pp = 1'b0;
            end
            if (!hp && $urandom_range(0, 99) < 40) begin
                hp = 1'b1; hw_r = 1'($urandom_range(0, 1));
                ha_r = 16'($urandom_range(0, 15)); hd_r = 16'($urandom);
            end else if (hp && $urandom_range(0, 99) < 4) begin
                hp = 1'b0;
            end
            rn = ($urandom_range(0, 399) != 0);
            step(rn, pp, pw_r, pa_r, pd_r, hp, hw_r, ha_r, hd_r);
            if (got_pg) pp = 1'b0;
            if (got_hg) hp = 1'b0;
        end
        idle(RD_LAT + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
